i2c_master_core: RTL and testbench
==================================

Name: i2c_master_core

Overview:
Bit/byte-level I2C master engine downstream of the I2CBlock CSR register file; consumes the enable/divider CSR values (e.g. EN @0x0400, DIV @0x0404) and a command stream, and drives the SCL/SDA open-drain pads.
- Executes one command at a time: START/RESTART, WRITE byte, READ byte with ACK, READ byte with NACK, STOP.
- Reports received data, ACK status and completion back to the CSR side.
- Pad tristates live in the block top; this core outputs only pull-low enables.

Parameters:
pDivWidth, 16, width of the quarter-bit divider input.

Ports:
iSysClk  in  1  system clock.
iSysRst  in  1  reset, asynchronous, active-high.
iEn  in  1  core enable (CSR EN bit).
iDiv  in  pDivWidth  system clocks per quarter SCL period (Q); 0 treated as 1.
iCmdVd  in  1  command valid.
iCmd  in  3  0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP, 5-7 no-op.
iWd  in  8  write byte, MSB first.
oCmdRdy  out  1  ready to accept a command.
oDone  out  1  one-cycle command-complete pulse.
oRd  out  8  last read byte.
oRdVd  out  1  one-cycle pulse with oDone for READ_*.
oAckErr  out  1  NACK seen on the last WRITE.
oBusy  out  1  command in progress.
oSclOe  out  1  1 = pull SCL low.
oSdaOe  out  1  1 = pull SDA low.
iSclIn  in  1  SCL pad level, pre-synchronised.
iSdaIn  in  1  SDA pad level, pre-synchronised.

Behaviour:
- Reset values: oSclOe, oSdaOe, oDone, oRdVd, oAckErr, oBusy = 0; oRd = 0; state IDLE.
- oCmdRdy is high only in IDLE with iEn=1.
- Accept: iCmdVd & oCmdRdy on cycle T.
  - iCmd, iWd and max(iDiv,1) are latched at T.
  - oCmdRdy falls and oBusy rises at T+1; the first quarter starts at T+1.
- Quarter tick: counter counts Q clocks.
  - Held while in phase Q1 with oSclOe=0 and iSclIn=0 (clock stretching).
  - Stretch cycles add 1:1 to latency.
- START (4 quarters; same sequence serves as repeated start):
  - Q0: SDA released, SCL unchanged.
  - Q1: SCL released.
  - Q2: SDA low.
  - Q3: SCL low.
- BIT (9 bits × 4 quarters = 36Q; bits 0-7 data, bit 8 ACK):
  - Q0: SCL low, set SDA.
  - Q1–Q2: SCL released.
  - Sample iSdaIn on the last clock of Q2.
  - Q3: SCL low.
- SDA ownership per command:
  - WRITE: oSdaOe = ~bit for data bits; released during the ACK bit; oAckErr = sampled ACK level, updated at completion.
  - READ_*: SDA released for data bits; oSdaOe=1 in the ACK bit for READ_ACK, 0 for READ_NACK; oRd updated at completion.
- STOP (4 quarters):
  - Q0: SCL low, SDA low.
  - Q1: SCL released.
  - Q2: SDA released.
  - Q3: idle.
  - Both lines are released at exit.
- Completion, no stretch: oDone at T+1+N·Q, with N = 4 (START/STOP) or 36 (byte).
  - oBusy falls and oCmdRdy rises in the same cycle as oDone.
  - Back-to-back: a command presented that cycle is accepted.
- No-op codes: oDone at T+1, no line activity, oAckErr unchanged.
- Between commands (IDLE after START/byte): oSclOe holds low and SDA keeps its last level, so the bus stays owned.
- iEn=0 in any state: next cycle returns to IDLE, both Oe=0, oBusy=0, no oDone/oRdVd, oRd/oAckErr unchanged.
- Async reset mid-command: same as reset values, immediately.
- iDiv/iWd changes during a command are ignored until the next accept.

Decomposition:
- Package i2c_pkg:
  - command enum: eSTART, eWRITE, eREAD_ACK, eREAD_NACK, eSTOP.
  - state enum: eIDLE, eSTART, eBIT, eSTOP.
  - localparams: lpQuarters=4, lpByteBits=9.
- Sub-module i2c_quarter_tick: divider counter with load and hold inputs; outputs a one-cycle tick at quarter end.

Test Plan:
- Reset, iEn=1, iDiv=4, START accepted at T:
  - oSdaOe rises at T+9, oSclOe rises at T+13.
  - oDone at T+17, oCmdRdy=1 at T+17.
- WRITE 0xA5 with slave ACK:
  - oSdaOe per bit (Q0–Q3) = 0,1,0,1,1,0,1,0.
  - oDone at T+145, oAckErr=0.
  - Repeat with slave NACK → oAckErr=1.
- READ_ACK with slave driving 0x3C:
  - oRd=0x3C, oRdVd pulses with oDone.
  - oSdaOe=1 during bit 8.
  - READ_NACK → oSdaOe=0 in bit 8.
- Clock stretch: slave holds iSclIn low 20 cycles in bit 3 Q1 → oDone delayed exactly 20 cycles versus the unstretched run.
- iEn dropped at byte quarter 10 → next cycle oSclOe=oSdaOe=0, oBusy=0, no oDone; async reset mid-STOP → all outputs at reset values immediately.
- iDiv=0 → START oDone at T+5; iDiv=250 → STOP oDone at T+1001; no-op code 6 → oDone at T+1, lines unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared command/state types and bit-level helpers for the I2C master core
package i2c_pkg;

    localparam int lpQuarters = 4;
    localparam int lpByteBits = 9;

    typedef enum logic [2:0] {
        eSTART     = 3'd0,
        eWRITE     = 3'd1,
        eREAD_ACK  = 3'd2,
        eREAD_NACK = 3'd3,
        eSTOP      = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        eS_IDLE  = 2'd0,
        eS_START = 2'd1,
        eS_BIT   = 2'd2,
        eS_STOP  = 2'd3
    } state_e;

    // SDA pull-low for byte bit idx (0-7 data MSB first, 8 = ACK slot)
    function automatic logic bit_sda_oe(input cmd_e cmd, input logic [7:0] wd, input logic [3:0] idx);
        logic [7:0] sh;
        sh = wd << idx[2:0];
        if (idx == 4'(lpByteBits - 1)) begin
            return (cmd == eREAD_ACK);
        end
        return (cmd == eWRITE) ? ~sh[7] : 1'b0;
    endfunction

endpackage

// File: rtl/i2c_master_core_if.sv
// rtl/i2c_master_core_if.sv - command/status and pad-level bundle between CSR side and I2C core
interface i2c_master_core_if #(parameter int pDivWidth = 16);
    logic                 iEn;
    logic [pDivWidth-1:0] iDiv;
    logic                 iCmdVd;
    logic [2:0]           iCmd;
    logic [7:0]           iWd;
    logic                 oCmdRdy;
    logic                 oDone;
    logic [7:0]           oRd;
    logic                 oRdVd;
    logic                 oAckErr;
    logic                 oBusy;
    logic                 oSclOe;
    logic                 oSdaOe;
    logic                 iSclIn;
    logic                 iSdaIn;

    modport master (
        output iEn, iDiv, iCmdVd, iCmd, iWd, iSclIn, iSdaIn,
        input  oCmdRdy, oDone, oRd, oRdVd, oAckErr, oBusy, oSclOe, oSdaOe
    );

    modport slave (
        input  iEn, iDiv, iCmdVd, iCmd, iWd, iSclIn, iSdaIn,
        output oCmdRdy, oDone, oRd, oRdVd, oAckErr, oBusy, oSclOe, oSdaOe
    );
endinterface

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - quarter-SCL-period divider with load (restart) and hold (stretch)
module i2c_quarter_tick #(
    parameter int pDivWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 hold,
    input  logic [pDivWidth-1:0] div,
    output logic                 tick
);
    logic [pDivWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (load) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (cnt_q == div - pDivWidth'(1)) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + pDivWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/i2c_master_core.sv
// rtl/i2c_master_core.sv - I2C master bit/byte engine: START, byte WRITE/READ, STOP with clock stretching
module i2c_master_core
    import i2c_pkg::*;
#(
    parameter int pDivWidth = 16
) (
    input  logic               iSysClk,
    input  logic               iSysRst,
    i2c_master_core_if.slave   bus
);
    state_e               state_q, state_d;
    cmd_e                 cmd_q, cmd_d;
    logic [1:0]           qtr_q, qtr_d;
    logic [3:0]           bit_q, bit_d;
    logic [7:0]           wd_q, wd_d;
    logic [8:0]           shift_q, shift_d;
    logic [pDivWidth-1:0] div_q, div_d;
    logic [7:0]           rd_q, rd_d;
    logic                 scl_oe_q, scl_oe_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 done_q, done_d;
    logic                 rdvd_q, rdvd_d;
    logic                 ackerr_q, ackerr_d;
    logic                 busy_q, busy_d;
    logic                 tick;
    logic                 hold;
    logic                 cmd_rdy;

    assign cmd_rdy = (state_q == eS_IDLE) && bus.iEn;
    // A slave holding SCL low while we have released it freezes the quarter counter
    assign hold    = (state_q != eS_IDLE) && (qtr_q == 2'd1) && !scl_oe_q && !bus.iSclIn;

    i2c_quarter_tick #(.pDivWidth(pDivWidth)) u_tick (
        .clk  (iSysClk),
        .rst  (iSysRst),
        .load (state_q == eS_IDLE),
        .hold (hold),
        .div  (div_q),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        wd_d     = wd_q;
        shift_d  = shift_q;
        div_d    = div_q;
        rd_d     = rd_q;
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        done_d   = 1'b0;
        rdvd_d   = 1'b0;
        ackerr_d = ackerr_q;
        busy_d   = busy_q;
        if (!bus.iEn) begin
            state_d  = eS_IDLE;
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                eS_IDLE: begin
                    if (bus.iCmdVd) begin
                        cmd_d = cmd_e'(bus.iCmd);
                        wd_d  = bus.iWd;
                        div_d = (bus.iDiv == '0) ? pDivWidth'(1) : bus.iDiv;
                        qtr_d = 2'd0;
                        bit_d = 4'd0;
                        case (cmd_e'(bus.iCmd))
                            eSTART: begin
                                state_d  = eS_START;
                                busy_d   = 1'b1;
                                sda_oe_d = 1'b0;
                            end
                            eWRITE, eREAD_ACK, eREAD_NACK: begin
                                state_d  = eS_BIT;
                                busy_d   = 1'b1;
                                scl_oe_d = 1'b1;
                                sda_oe_d = bit_sda_oe(cmd_e'(bus.iCmd), bus.iWd, 4'd0);
                            end
                            eSTOP: begin
                                state_d  = eS_STOP;
                                busy_d   = 1'b1;
                                scl_oe_d = 1'b1;
                                sda_oe_d = 1'b1;
                            end
                            default: done_d = 1'b1;
                        endcase
                    end
                end
                // On each tick the outputs for the following quarter are loaded
                eS_START: begin
                    if (tick) begin
                        qtr_d = qtr_q + 2'd1;
                        case (qtr_q)
                            2'd0: scl_oe_d = 1'b0;
                            2'd1: sda_oe_d = 1'b1;
                            2'd2: scl_oe_d = 1'b1;
                            default: begin
                                state_d = eS_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
                eS_BIT: begin
                    if (tick) begin
                        qtr_d = qtr_q + 2'd1;
                        case (qtr_q)
                            2'd0: scl_oe_d = 1'b0;
                            2'd1: ;
                            2'd2: begin
                                scl_oe_d = 1'b1;
                                shift_d  = {shift_q[7:0], bus.iSdaIn};
                            end
                            default: begin
                                if (bit_q == 4'(lpByteBits - 1)) begin
                                    state_d = eS_IDLE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                    if (cmd_q == eWRITE) begin
                                        ackerr_d = shift_q[0];
                                    end else begin
                                        rd_d   = shift_q[8:1];
                                        rdvd_d = 1'b1;
                                    end
                                end else begin
                                    bit_d    = bit_q + 4'd1;
                                    sda_oe_d = bit_sda_oe(cmd_q, wd_q, bit_q + 4'd1);
                                end
                            end
                        endcase
                    end
                end
                eS_STOP: begin
                    if (tick) begin
                        qtr_d = qtr_q + 2'd1;
                        case (qtr_q)
                            2'd0: scl_oe_d = 1'b0;
                            2'd1: sda_oe_d = 1'b0;
                            2'd2: ;
                            default: begin
                                state_d  = eS_IDLE;
                                busy_d   = 1'b0;
                                done_d   = 1'b1;
                                scl_oe_d = 1'b0;
                                sda_oe_d = 1'b0;
                            end
                        endcase
                    end
                end
                default: state_d = eS_IDLE;
            endcase
        end
    end

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            state_q  <= eS_IDLE;
            cmd_q    <= eSTART;
            qtr_q    <= 2'd0;
            bit_q    <= 4'd0;
            wd_q     <= 8'd0;
            shift_q  <= 9'd0;
            div_q    <= pDivWidth'(1);
            rd_q     <= 8'd0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            done_q   <= 1'b0;
            rdvd_q   <= 1'b0;
            ackerr_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            wd_q     <= wd_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            rd_q     <= rd_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            done_q   <= done_d;
            rdvd_q   <= rdvd_d;
            ackerr_q <= ackerr_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.oCmdRdy = cmd_rdy;
    assign bus.oDone   = done_q;
    assign bus.oRd     = rd_q;
    assign bus.oRdVd   = rdvd_q;
    assign bus.oAckErr = ackerr_q;
    assign bus.oBusy   = busy_q;
    assign bus.oSclOe  = scl_oe_q;
    assign bus.oSdaOe  = sda_oe_q;
endmodule

// File: tb/tb_i2c_master_core.sv
// tb/tb_i2c_master_core.sv - directed self-checking bench for i2c_master_core
module tb_i2c_master_core;
    logic       clk;
    logic       rst;
    logic       tb_load;
    logic       stretch;
    logic [8:0] slave_pat;
    logic [3:0] sidx;
    logic       scl_prev;
    logic       slave_bit;
    int         errs;
    int         checks;
    int         rel;
    int         nd;
    logic [7:0] obs;

    i2c_master_core_if #(.pDivWidth(16)) bus ();

    i2c_master_core #(.pDivWidth(16)) dut (
        .iSysClk (clk),
        .iSysRst (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Open-drain pads with a simple slave: stretch holds SCL, pattern bit advances on each SCL fall
    assign slave_bit  = (sidx < 4'd9) ? slave_pat[4'd8 - sidx] : 1'b1;
    assign bus.iSclIn = ~bus.oSclOe & ~stretch;
    assign bus.iSdaIn = ~bus.oSdaOe & slave_bit;

    always @(posedge clk) begin
        scl_prev <= bus.iSclIn;
        if (tb_load) sidx <= 4'd0;
        else if (scl_prev && !bus.iSclIn && sidx < 4'd9) sidx <= sidx + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic accept(input logic [2:0] c, input logic [7:0] w);
        chk("cmd_rdy_before_accept", 32'(bus.oCmdRdy), 32'd1);
        bus.iCmd   = c;
        bus.iWd    = w;
        bus.iCmdVd = 1'b1;
        tb_load    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.iCmdVd = 1'b0;
        tb_load    = 1'b0;
        rel        = 1;
    endtask

    task automatic go(input int n);
        while (rel < n) begin
            @(negedge clk);
            rel++;
        end
    endtask

    task automatic wait_done(input int limit);
        while (!bus.oDone && rel < limit) begin
            @(negedge clk);
            rel++;
        end
        chk("done_seen", 32'(bus.oDone), 32'd1);
    endtask

    initial begin
        errs = 0; checks = 0; rel = 0;
        rst = 1'b1; tb_load = 1'b0; stretch = 1'b0; slave_pat = 9'h1FF; scl_prev = 1'b1;
        bus.iEn = 1'b0; bus.iDiv = 16'd4; bus.iCmdVd = 1'b0; bus.iCmd = 3'd0; bus.iWd = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", 32'(bus.oSclOe), 32'd0);
        chk("rst_sda_oe", 32'(bus.oSdaOe), 32'd0);
        chk("rst_flags", {28'd0, bus.oDone, bus.oRdVd, bus.oAckErr, bus.oBusy}, 32'd0);
        chk("rst_rd", 32'(bus.oRd), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_en0", 32'(bus.oCmdRdy), 32'd0);
        bus.iEn = 1'b1;
        #1;
        chk("rdy_en1", 32'(bus.oCmdRdy), 32'd1);
        @(negedge clk);

        // START, Q=4
        accept(3'd0, 8'h00);
        chk("start_busy", 32'(bus.oBusy), 32'd1);
        chk("start_rdy_low", 32'(bus.oCmdRdy), 32'd0);
        go(8);  chk("start_sda_t8", 32'(bus.oSdaOe), 32'd0);
        go(9);  chk("start_sda_t9", 32'(bus.oSdaOe), 32'd1);
        go(12); chk("start_scl_t12", 32'(bus.oSclOe), 32'd0);
        go(13); chk("start_scl_t13", 32'(bus.oSclOe), 32'd1);
        wait_done(40);
        chk("start_done_time", rel, 32'd17);
        chk("start_done_rdy", {30'd0, bus.oCmdRdy, bus.oBusy}, 32'b10);

        // WRITE 0xA5 with ACK
        slave_pat = 9'h1FE;
        accept(3'd1, 8'hA5);
        for (int b = 0; b < 8; b++) begin
            go(1 + 16 * b + 1);
            obs[7 - b] = bus.oSdaOe;
        end
        chk("wr_sda_bits", 32'(obs), 32'h5A);
        go(130); chk("wr_ack_released", 32'(bus.oSdaOe), 32'd0);
        wait_done(200);
        chk("wr_done_time", rel, 32'd145);
        chk("wr_ackerr_ack", 32'(bus.oAckErr), 32'd0);

        // WRITE 0xA5 with NACK
        slave_pat = 9'h1FF;
        accept(3'd1, 8'hA5);
        wait_done(200);
        chk("wrn_done_time", rel, 32'd145);
        chk("wrn_ackerr", 32'(bus.oAckErr), 32'd1);

        // READ_ACK of 0x3C, then READ_NACK of 0xC3 back to back
        slave_pat = {8'h3C, 1'b1};
        accept(3'd2, 8'h00);
        go(2);   chk("rda_data_released", 32'(bus.oSdaOe), 32'd0);
        go(130); chk("rda_ack_driven", 32'(bus.oSdaOe), 32'd1);
        wait_done(200);
        chk("rda_done_time", rel, 32'd145);
        chk("rda_rdvd", 32'(bus.oRdVd), 32'd1);
        chk("rda_rd", 32'(bus.oRd), 32'h3C);
        chk("rda_ackerr_kept", 32'(bus.oAckErr), 32'd1);
        slave_pat = {8'hC3, 1'b1};
        accept(3'd3, 8'h00);
        chk("rdn_rdvd_low", 32'(bus.oRdVd), 32'd0);
        go(130); chk("rdn_ack_released", 32'(bus.oSdaOe), 32'd0);
        wait_done(200);
        chk("rdn_done_time", rel, 32'd145);
        chk("rdn_rd_rdvd", {23'd0, bus.oRdVd, bus.oRd}, {23'd0, 1'b1, 8'hC3});

        // Stretch: SCL held low 20 cycles in bit 3 Q1
        slave_pat = 9'h1FE;
        accept(3'd1, 8'h00);
        go(52); stretch = 1'b1;
        go(73); stretch = 1'b0;
        wait_done(260);
        chk("stretch_done_time", rel, 32'd165);
        chk("stretch_ackerr", 32'(bus.oAckErr), 32'd0);

        // iEn dropped at byte quarter 10
        accept(3'd1, 8'h00);
        go(41); chk("en_drop_pre_sda", 32'(bus.oSdaOe), 32'd1);
        bus.iEn = 1'b0;
        go(42);
        chk("en_drop_lines", {30'd0, bus.oSclOe, bus.oSdaOe}, 32'd0);
        chk("en_drop_busy_done", {30'd0, bus.oBusy, bus.oDone}, 32'd0);
        nd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.oDone) nd++;
        end
        chk("en_drop_no_done", nd, 32'd0);
        chk("en_drop_ackerr_kept", 32'(bus.oAckErr), 32'd0);
        bus.iEn = 1'b1;
        @(negedge clk);

        // STOP with Q=250; later iDiv change is ignored
        bus.iDiv = 16'd250;
        accept(3'd4, 8'h00);
        bus.iDiv = 16'd4;
        chk("stop_q0", {30'd0, bus.oSclOe, bus.oSdaOe}, 32'b11);
        go(251); chk("stop_q1", {30'd0, bus.oSclOe, bus.oSdaOe}, 32'b01);
        go(501); chk("stop_q2", {30'd0, bus.oSclOe, bus.oSdaOe}, 32'b00);
        wait_done(1100);
        chk("stop_done_time", rel, 32'd1001);

        // iDiv=0 START, then no-op code 6 back to back
        bus.iDiv = 16'd0;
        accept(3'd0, 8'h00);
        wait_done(60);
        chk("div0_start_time", rel, 32'd5);
        accept(3'd6, 8'h00);
        chk("noop_done", 32'(bus.oDone), 32'd1);
        chk("noop_lines_busy", {29'd0, bus.oSclOe, bus.oSdaOe, bus.oBusy}, 32'b110);
        chk("noop_ackerr", 32'(bus.oAckErr), 32'd0);

        // NACKed write sets AckErr, then async reset during STOP
        bus.iDiv = 16'd4;
        slave_pat = 9'h1FF;
        accept(3'd1, 8'hFF);
        wait_done(200);
        chk("wrff_ackerr", 32'(bus.oAckErr), 32'd1);
        accept(3'd4, 8'h00);
        go(6);
        chk("stop_busy_pre_rst", 32'(bus.oBusy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_lines", {30'd0, bus.oSclOe, bus.oSdaOe}, 32'd0);
        chk("arst_flags", {28'd0, bus.oDone, bus.oRdVd, bus.oAckErr, bus.oBusy}, 32'd0);
        chk("arst_rd", 32'(bus.oRd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
